quad_gen: RTL and testbench



---
 rtl/quad_gen.sv | 112 +++++++++++
 tb/tb_quad_gen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_gen.sv
// Quadrature waveform generator: turns detent step commands into the Gray-code
// quadA/quadB edge train a rotary encoder produces, one edge every EDGE_DIV clocks.
module quad_gen #(
   parameter int EDGE_DIV         = 50000,
   parameter int EDGES_PER_DETENT = 4
) (
   input  logic       clk50,
   input  logic       reset,
   input  logic       step_valid,
   input  logic [1:0] step_dir,
   input  logic [7:0] step_count,
   output logic       step_ready,
   input  logic       abort,
   output logic       quadA,
   output logic       quadB,
   output logic       busy,
   output logic       detent_done,
   output logic       cmd_error,
   output logic [7:0] position
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [23:0] DIV_M1    = 24'(EDGE_DIV - 1);
   localparam logic [1:0]  LAST_EDGE = 2'(EDGES_PER_DETENT - 1);

   state_t      state;
   logic [1:0]  phase;
   logic        dir_right;
   logic [7:0]  detents_left;
   logic [1:0]  edge_in_detent;
   logic [23:0] timer;

   logic        fire;
   logic        legal;
   logic [1:0]  phase_nxt;

   function automatic logic [1:0] ab_of(input logic [1:0] p);
      case (p)
         2'd0:    ab_of = 2'b00;
         2'd1:    ab_of = 2'b10;
         2'd2:    ab_of = 2'b11;
         default: ab_of = 2'b01;
      endcase
   endfunction

   assign fire      = step_valid & step_ready & ~abort;
   assign legal     = ((step_dir == 2'b10) || (step_dir == 2'b01)) && (step_count != 8'd0);
   assign phase_nxt = dir_right ? phase + 2'd1 : phase - 2'd1;

   always_ff @(posedge clk50) begin
      if (reset) begin
         state          <= IDLE;
         phase          <= 2'd0;
         quadA          <= 1'b0;
         quadB          <= 1'b0;
         step_ready     <= 1'b1;
         busy           <= 1'b0;
         detent_done    <= 1'b0;
         cmd_error      <= 1'b0;
         position       <= 8'd0;
         timer          <= 24'd0;
         dir_right      <= 1'b0;
         detents_left   <= 8'd0;
         edge_in_detent <= 2'd0;
      end else begin
         detent_done <= 1'b0;
         cmd_error   <= 1'b0;
         case (state)
            IDLE: begin
               if (fire) begin
                  if (legal) begin
                     state          <= RUN;
                     step_ready     <= 1'b0;
                     busy           <= 1'b1;
                     dir_right      <= step_dir[1];
                     detents_left   <= step_count;
                     edge_in_detent <= 2'd0;
                     // the handshake cycle counts as tick 0, so edge k lands k*EDGE_DIV after it
                     timer          <= 24'd1;
                  end else begin
                     cmd_error <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort || detents_left == 8'd0) begin
                  // phase is held where it is; a partial detent is simply dropped
                  state      <= IDLE;
                  step_ready <= 1'b1;
                  busy       <= 1'b0;
                  timer      <= 24'd0;
               end else if (timer == DIV_M1) begin
                  timer          <= 24'd0;
                  phase          <= phase_nxt;
                  {quadA, quadB} <= ab_of(phase_nxt);
                  edge_in_detent <= edge_in_detent + 2'd1;
                  if (edge_in_detent == LAST_EDGE) begin
                     detent_done  <= 1'b1;
                     position     <= dir_right ? position + 8'd1 : position - 8'd1;
                     detents_left <= detents_left - 8'd1;
                  end
               end else begin
                  timer <= timer + 24'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_quad_gen.sv
// Bench for quad_gen: directed scenarios with literal expectations plus random
// commands/aborts/resets checked every cycle against an edge-count model.
module tb_quad_gen;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       step_valid = 1'b0;
   logic [1:0] step_dir = 2'b00;
   logic [7:0] step_count = 8'd0;
   logic       abort = 1'b0;
   logic       step_ready, quadA, quadB, busy, detent_done, cmd_error;
   logic [7:0] position;

   quad_gen #(.EDGE_DIV(D), .EDGES_PER_DETENT(4)) dut (
      .clk50(clk), .reset(reset), .step_valid(step_valid), .step_dir(step_dir),
      .step_count(step_count), .step_ready(step_ready), .abort(abort),
      .quadA(quadA), .quadB(quadB), .busy(busy), .detent_done(detent_done),
      .cmd_error(cmd_error), .position(position)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int mod4(input int x);
      return ((x % 4) + 4) % 4;
   endfunction

   function automatic logic [1:0] ab_tab(input int p);
      logic [1:0] t [4];
      t = '{2'b00, 2'b10, 2'b11, 2'b01};
      return t[mod4(p)];
   endfunction

   function automatic int gidx(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Model: a command accepted in cycle T shows min(j/D, 4N) edges in cycle T+j.
   bit m_on = 0, m_run = 0, m_err = 0;
   int m_j = 0, m_n = 0, m_dir = 0, m_ph = 0, m_pos = 0;

   function automatic int edges_now();
      return (m_j / D < 4 * m_n) ? m_j / D : 4 * m_n;
   endfunction

   always @(posedge clk) begin : model
      int e;
      if (reset) begin
         m_on = 1; m_run = 0; m_ph = 0; m_pos = 0; m_err = 0;
      end else if (m_run) begin
         m_err = 0;
         if (abort || m_j == 4 * m_n * D) begin
            e = edges_now();
            m_ph  = mod4(m_ph + m_dir * e);
            m_pos = (m_pos + m_dir * (e / 4)) & 255;
            m_run = 0;
         end else m_j++;
      end else begin
         m_err = 0;
         if (step_valid && !abort) begin
            if ((step_dir == 2'b10 || step_dir == 2'b01) && step_count != 0) begin
               m_run = 1; m_j = 1; m_n = step_count;
               m_dir = (step_dir == 2'b10) ? 1 : -1;
            end else m_err = 1;
         end
      end
   end

   // Loopback decoder: 2-FF synchroniser, one dir pulse per 4 net Gray steps.
   logic [1:0] sy1 = 2'b00, sy2 = 2'b00, sy3 = 2'b00;
   int acc = 0, dec_r = 0, dec_l = 0;
   always @(posedge clk) begin : decoder
      int d;
      if (reset) acc = 0;
      else if (sy2 != sy3) begin
         d = mod4(gidx(sy2) - gidx(sy3));
         if (d == 1) acc++;
         else if (d == 3) acc--;
         if (acc == 4) begin dec_r++; acc = 0; end
         if (acc == -4) begin dec_l++; acc = 0; end
      end
      sy3 <= sy2; sy2 <= sy1; sy1 <= {quadA, quadB};
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic at(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1; step_valid = 0; abort = 0;
      repeat (4) @(negedge clk);
      reset = 0;
   endtask

   task automatic send(input logic [1:0] d, input logic [7:0] c, output int t);
      int guard;
      guard = 0;
      step_dir = d; step_count = c; step_valid = 1;
      while (step_ready !== 1'b1 && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      t = cyc;
      if (guard >= 20000) begin
         tests++; fails++;
         $display("FAIL handshake timeout: step_ready got %b, required 1", step_ready);
      end
      @(negedge clk);
      step_valid = 0;
   endtask

   initial begin
      fork
         begin : monitor
            forever begin
               int e, ph, pos;
               bit bz, dn;
               logic [14:0] exp_v, act_v;
               @(negedge clk);
               if (m_on) begin
                  if (m_run) begin
                     e = edges_now();
                     ph = mod4(m_ph + m_dir * e);
                     pos = (m_pos + m_dir * (e / 4)) & 255;
                     bz = 1; dn = (m_j % (4 * D) == 0);
                  end else begin
                     ph = m_ph; pos = m_pos; bz = 0; dn = 0;
                  end
                  exp_v = {ab_tab(ph), bz, !bz, dn, m_err, 8'(pos), 1'b0};
                  act_v = {quadA, quadB, busy, step_ready, detent_done, cmd_error, position, 1'b0};
                  tests++;
                  if (act_v !== exp_v) begin
                     fails++;
                     $display("FAIL model cycle %0d: got AB=%b busy=%b rdy=%b done=%b err=%b pos=%0d, required AB=%b busy=%b rdy=%b done=%b err=%b pos=%0d",
                              cyc, act_v[14:13], act_v[12], act_v[11], act_v[10], act_v[9], act_v[8:1],
                              exp_v[14:13], exp_v[12], exp_v[11], exp_v[10], exp_v[9], exp_v[8:1]);
                  end
               end
            end
         end
         begin : main
            int t, t2, r0, l0, r;
            logic [1:0] ab0, d;
            logic [7:0] c;
            logic [1:0] exp_b [8];
            logic [1:0] exp_e [4];
            exp_b = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
            exp_e = '{2'b10, 2'b00, 2'b01, 2'b11};

            @(negedge clk);
            do_reset();
            chk("reset_ab", {quadA, quadB}, 2'b00);
            chk("reset_rdy_busy", {step_ready, busy}, 2'b10);
            chk("reset_pos", position, 0);
            chk("reset_pulses", {detent_done, cmd_error}, 2'b00);

            // one right detent
            send(2'b10, 8'd1, t);
            at(t + 4);  chk("r1_edge1", {quadA, quadB}, 2'b10);
            at(t + 8);  chk("r1_edge2", {quadA, quadB}, 2'b11);
            at(t + 12); chk("r1_edge3", {quadA, quadB}, 2'b01);
            at(t + 16); chk("r1_edge4", {quadA, quadB}, 2'b00);
            chk("r1_done", detent_done, 1); chk("r1_pos", position, 1);
            chk("r1_rdy_low", step_ready, 0);
            at(t + 17); chk("r1_rdy_back", {step_ready, busy}, 2'b10);

            // two left detents from phase 0
            do_reset();
            send(2'b01, 8'd2, t);
            for (int k = 1; k <= 8; k++) begin
               at(t + 4 * k);
               chk("l2_edge", {quadA, quadB}, exp_b[k-1]);
               if (k == 4) chk("l2_pos1", position, 255);
               if (k == 8) chk("l2_pos2", position, 254);
            end

            // second command waits while busy, accepted in first idle cycle
            send(2'b10, 8'd2, t);
            send(2'b01, 8'd1, t2);
            chk("b2b_accept", t2 - t, 33);
            at(t2 + 17);
            chk("b2b_pos", position, 255);

            // loopback into decoder
            do_reset();
            r0 = dec_r; l0 = dec_l;
            send(2'b10, 8'd3, t);
            at(t + 56);
            chk("loop_right", dec_r - r0, 3); chk("loop_right_l", dec_l - l0, 0);
            send(2'b01, 8'd3, t);
            at(t + 56);
            chk("loop_left", dec_l - l0, 3); chk("loop_pos", position, 0);

            // illegal commands
            for (int i = 0; i < 3; i++) begin
               ab0 = {quadA, quadB};
               if (i == 0) send(2'b11, 8'd2, t);
               else if (i == 1) send(2'b00, 8'd2, t);
               else send(2'b10, 8'd0, t);
               at(t + 1);
               chk("ill_err", cmd_error, 1); chk("ill_busy", busy, 0);
               chk("ill_ab", {quadA, quadB}, ab0);
               at(t + 2); chk("ill_err_once", cmd_error, 0);
            end

            // abort after edge 2
            do_reset();
            send(2'b10, 8'd1, t);
            at(t + 9);
            abort = 1;
            @(negedge clk);
            abort = 0;
            chk("abort_ab", {quadA, quadB}, 2'b11);
            chk("abort_idle", {step_ready, busy}, 2'b10);
            at(t + 16);
            chk("abort_nodone", detent_done, 0); chk("abort_pos", position, 0);
            send(2'b01, 8'd1, t);
            for (int k = 1; k <= 4; k++) begin
               at(t + 4 * k);
               chk("abort_next_edge", {quadA, quadB}, exp_e[k-1]);
            end
            chk("abort_next_pos", position, 255);

            // reset mid-run at AB=01
            do_reset();
            send(2'b10, 8'd1, t);
            at(t + 12);
            chk("rst_pre_ab", {quadA, quadB}, 2'b01);
            reset = 1;
            @(negedge clk);
            reset = 0;
            chk("rst_ab", {quadA, quadB}, 2'b00);
            chk("rst_pos", position, 0); chk("rst_rdy", step_ready, 1);

            // position wrap 127 -> 128
            do_reset();
            send(2'b10, 8'd127, t);
            at(t + 127 * 16 + 1);
            chk("wrap_127", position, 127);
            send(2'b10, 8'd1, t);
            at(t + 16);
            chk("wrap_128", position, 128);

            // random commands, aborts, resets
            for (int it = 0; it < 80; it++) begin
               r = $urandom_range(0, 9);
               case ($urandom_range(0, 9))
                  0: d = 2'b00;
                  1: d = 2'b11;
                  2, 3, 4, 5: d = 2'b10;
                  default: d = 2'b01;
               endcase
               c = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
               if (r == 4) begin
                  step_valid = 1; abort = 1; step_dir = 2'b10; step_count = 8'd1;
                  @(negedge clk);
                  step_valid = 0; abort = 0;
               end
               send(d, c, t);
               if (r < 3) begin
                  repeat ($urandom_range(0, 30)) @(negedge clk);
                  abort = 1;
                  @(negedge clk);
                  abort = 0;
               end else if (r == 3) begin
                  repeat ($urandom_range(1, 30)) @(negedge clk);
                  reset = 1;
                  @(negedge clk);
                  reset = 0;
               end else begin
                  repeat ($urandom_range(0, 40)) @(negedge clk);
               end
            end
            repeat (60) @(negedge clk);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
         end
         begin : watchdog
            #3000000;
            fails++;
            $display("FAIL watchdog: got cycle %0d without finishing, required completion", cyc);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
         end
      join_any
   end

endmodule
